// File: rtl/prog_seq_pkg.sv
// Shared encodings for the prog_sequencer fetch/execute datapath:
// RV32 opcode and funct3 constants, FSM states, memory size codes.
package prog_seq_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;
    localparam logic [2:0] F3_ADDI = 3'b000;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {FETCH, EXEC, MEM} state_e;

    // f3[2] selects zero extension; size code 2 (and above) passes the word through
    function automatic logic [31:0] load_ext(logic [31:0] d, logic [2:0] f3);
        case (f3[1:0])
            SIZE_BYTE: return f3[2] ? {24'b0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            SIZE_HALF: return f3[2] ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default:   return d;
        endcase
    endfunction

    function automatic logic [31:0] store_data(logic [31:0] d, logic [1:0] sz);
        case (sz)
            SIZE_BYTE: return {24'b0, d[7:0]};
            SIZE_HALF: return {16'b0, d[15:0]};
            default:   return d;
        endcase
    endfunction

endpackage

// File: rtl/prog_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, x0 hardwired to zero, no reset.
module prog_regfile #(
    parameter int unsigned NREGS = 32,
    localparam int unsigned IW = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic [IW-1:0] rs1_i,
    input  logic [IW-1:0] rs2_i,
    output logic [31:0]   rs1_data_o,
    output logic [31:0]   rs2_data_o,
    input  logic          we_i,
    input  logic [IW-1:0] rd_i,
    input  logic [31:0]   rd_data_i
);

    logic [31:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (we_i && (rd_i != '0)) begin
            regs_q[rd_i] <= rd_data_i;
        end
    end

    assign rs1_data_o = (rs1_i == '0) ? '0 : regs_q[rs1_i];
    assign rs2_data_o = (rs2_i == '0) ? '0 : regs_q[rs2_i];

endmodule

// File: rtl/prog_sequencer.sv
// Multi-cycle RV32 fetch/execute sequencer over a handshaked memory port with
// wait states; owns the PC and register file.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int unsigned   AW        = 32,
    parameter int unsigned   NREGS     = 32,
    parameter bit            BYTE_ADDR = 1'b1,
    parameter logic [AW-1:0] RESET_PC  = '0
) (
    input  logic          clk,
    input  logic          rts_n,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [1:0]    mem_size,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ready,
    output logic [AW-1:0] prc,
    output logic          illegal
);

    localparam int unsigned   IW   = $clog2(NREGS);
    localparam logic [AW-1:0] STEP = BYTE_ADDR ? AW'(4) : AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, prc_q, prc_d;
    logic [31:0]   instr_q, instr_d;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, off_b, off_j;
    logic signed [31:0] imm_b_s, imm_j_s;
    logic [31:0] rs1_val, rs2_val, ea, jalr_t, link;
    logic        is_store, legal, taken, req_c, we_c, rf_we;
    logic [31:0] rf_wdata;

    assign opcode   = instr_q[6:0];
    assign f3       = instr_q[14:12];
    assign is_store = (opcode == OP_STORE);

    assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_u = {instr_q[31:12], 12'b0};
    assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

    // Word-addressed memory: byte offsets become word offsets (arithmetic shift)
    assign imm_b_s = imm_b;
    assign imm_j_s = imm_j;
    assign off_b   = BYTE_ADDR ? imm_b : 32'(imm_b_s >>> 2);
    assign off_j   = BYTE_ADDR ? imm_j : 32'(imm_j_s >>> 2);

    assign ea     = rs1_val + (is_store ? imm_s : imm_i);
    assign jalr_t = (rs1_val + imm_i) & ~32'd1;
    assign link   = 32'(prc_q + STEP);

    prog_regfile #(.NREGS(NREGS)) u_rf (
        .clk        (clk),
        .rs1_i      (instr_q[15 +: IW]),
        .rs2_i      (instr_q[20 +: IW]),
        .rs1_data_o (rs1_val),
        .rs2_data_o (rs2_val),
        .we_i       (rf_we),
        .rd_i       (instr_q[7 +: IW]),
        .rd_data_i  (rf_wdata)
    );

    always_comb begin
        taken = 1'b0;
        case (f3)
            F3_BEQ:  taken = (rs1_val == rs2_val);
            F3_BNE:  taken = (rs1_val != rs2_val);
            F3_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: taken = (rs1_val <  rs2_val);
            F3_BGEU: taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: legal = 1'b1;
            OP_OPIMM:                          legal = (f3 == F3_ADDI);
            OP_BRANCH:                         legal = (f3[2:1] != 2'b01);
            OP_LOAD, OP_STORE:                 legal = (f3[1:0] != 2'b11);
            default:                           legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        prc_d     = prc_q;
        instr_d   = instr_q;
        req_c     = 1'b0;
        we_c      = 1'b0;
        mem_addr  = pc_q;
        mem_size  = SIZE_WORD;
        mem_wdata = '0;
        illegal   = 1'b0;
        rf_we     = 1'b0;
        rf_wdata  = '0;
        case (state_q)
            FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    instr_d = mem_rdata;
                    prc_d   = pc_q;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = prc_q + STEP;
                if (!legal) begin
                    illegal = 1'b1;
                end else begin
                    case (opcode)
                        OP_LUI:    begin rf_we = 1'b1; rf_wdata = imm_u; end
                        OP_AUIPC:  begin rf_we = 1'b1; rf_wdata = 32'(prc_q) + imm_u; end
                        OP_OPIMM:  begin rf_we = 1'b1; rf_wdata = rs1_val + imm_i; end
                        OP_JAL:    begin rf_we = 1'b1; rf_wdata = link; pc_d = prc_q + AW'(off_j); end
                        OP_JALR:   begin rf_we = 1'b1; rf_wdata = link; pc_d = AW'(jalr_t); end
                        OP_BRANCH: if (taken) pc_d = prc_q + AW'(off_b);
                        OP_LOAD, OP_STORE: begin pc_d = pc_q; state_d = MEM; end
                        default: ;
                    endcase
                end
            end
            MEM: begin
                req_c     = 1'b1;
                we_c      = is_store;
                mem_addr  = AW'(ea);
                mem_size  = f3[1:0];
                mem_wdata = is_store ? store_data(rs2_val, f3[1:0]) : '0;
                if (mem_ready) begin
                    rf_we    = !is_store;
                    rf_wdata = load_ext(mem_rdata, f3);
                    pc_d     = prc_q + STEP;
                    state_d  = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset gates the request combinationally so an in-flight access drops at once
    assign mem_req = req_c & rts_n;
    assign mem_we  = we_c & rts_n;
    assign prc     = prc_q;

    always_ff @(posedge clk or negedge rts_n) begin
        if (!rts_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            prc_q   <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            prc_q   <= prc_d;
            instr_q <= instr_d;
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed, table-driven bench for prog_sequencer: one byte-addressed and one
// word-addressed instance, each fed instruction by instruction from a vector table.
module tb_prog_sequencer;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, LUI = 7'b0110111,
                           AUIPC = 7'b0010111, OPIMM = 7'b0010011, JAL = 7'b1101111,
                           JALR = 7'b1100111, BRANCH = 7'b1100011;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ill;
        logic        mem;
        logic        we;
        logic [31:0] maddr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } vec_t;

    logic        clk = 1'b0;
    logic        rts_n;
    logic        mem_req [2];
    logic        mem_we [2];
    logic [31:0] mem_addr [2];
    logic [1:0]  mem_size [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        mem_ready [2];
    logic [31:0] prc [2];
    logic        illegal [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prog_sequencer #(.AW(32), .NREGS(32), .BYTE_ADDR(1'b1), .RESET_PC(32'h100)) dut_a (
        .clk(clk), .rts_n(rts_n), .mem_req(mem_req[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_size(mem_size[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]), .prc(prc[0]), .illegal(illegal[0])
    );

    prog_sequencer #(.AW(32), .NREGS(32), .BYTE_ADDR(1'b0), .RESET_PC(32'h100)) dut_b (
        .clk(clk), .rts_n(rts_n), .mem_req(mem_req[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_size(mem_size[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]), .prc(prc[1]), .illegal(illegal[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(int imm, int rs1, logic [2:0] f3, int rd, logic [6:0] op);
        logic [31:0] im = imm;
        return {im[11:0], 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, logic [2:0] f3);
        logic [31:0] im = imm;
        return {im[11:5], 5'(rs2), 5'(rs1), f3, im[4:0], STORE};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, logic [2:0] f3);
        logic [31:0] im = imm;
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], BRANCH};
    endfunction

    function automatic logic [31:0] enc_u(logic [19:0] imm20, int rd, logic [6:0] op);
        return {imm20, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] im = imm;
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), JAL};
    endfunction

    function automatic vec_t v_op(logic [31:0] instr, logic [31:0] pc, logic ill);
        vec_t v = '{instr: instr, pc: pc, ill: ill, mem: 1'b0, we: 1'b0, maddr: '0,
                    size: 2'd0, wdata: '0, rdata: '0, waits: 0};
        return v;
    endfunction

    function automatic vec_t v_st(logic [31:0] instr, logic [31:0] pc, logic [31:0] a,
                                  logic [1:0] sz, logic [31:0] wd, int waits);
        vec_t v = '{instr: instr, pc: pc, ill: 1'b0, mem: 1'b1, we: 1'b1, maddr: a,
                    size: sz, wdata: wd, rdata: '0, waits: waits};
        return v;
    endfunction

    function automatic vec_t v_ld(logic [31:0] instr, logic [31:0] pc, logic [31:0] a,
                                  logic [1:0] sz, logic [31:0] rd, int waits);
        vec_t v = '{instr: instr, pc: pc, ill: 1'b0, mem: 1'b1, we: 1'b0, maddr: a,
                    size: sz, wdata: '0, rdata: rd, waits: waits};
        return v;
    endfunction

    // Entered on a negedge with the DUT in FETCH; leaves on the negedge of the next FETCH.
    task automatic run_vec(input int d, input vec_t v, input int i, input int fw);
        string p = $sformatf("%s%0d", (d == 0) ? "a" : "b", i);
        for (int w = 0; w <= fw; w++) begin
            chk({p, "_freq"}, 32'(mem_req[d]), 32'd1);
            chk({p, "_faddr"}, mem_addr[d], v.pc);
            if (w == 0) begin
                chk({p, "_fwe"}, 32'(mem_we[d]), 32'd0);
                chk({p, "_fsize"}, 32'(mem_size[d]), 32'd2);
                chk({p, "_fill"}, 32'(illegal[d]), 32'd0);
            end
            if (w == fw) begin
                mem_rdata[d] = v.instr;
                mem_ready[d] = 1'b1;
            end
            @(negedge clk);
            mem_ready[d] = 1'b0;
            mem_rdata[d] = '0;
        end
        chk({p, "_xreq"}, 32'(mem_req[d]), 32'd0);
        chk({p, "_prc"}, prc[d], v.pc);
        chk({p, "_ill"}, 32'(illegal[d]), 32'(v.ill));
        @(negedge clk);
        if (v.mem) begin
            for (int w = 0; w <= v.waits; w++) begin
                chk({p, "_mreq"}, 32'(mem_req[d]), 32'd1);
                chk({p, "_mwe"}, 32'(mem_we[d]), 32'(v.we));
                chk({p, "_maddr"}, mem_addr[d], v.maddr);
                chk({p, "_msize"}, 32'(mem_size[d]), 32'(v.size));
                if (v.we) chk({p, "_wdata"}, mem_wdata[d], v.wdata);
                if (w == v.waits) begin
                    mem_rdata[d] = v.rdata;
                    mem_ready[d] = 1'b1;
                end
                @(negedge clk);
                mem_ready[d] = 1'b0;
                mem_rdata[d] = '0;
            end
        end
    endtask

    vec_t ta[$];
    vec_t tb_w[$];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rts_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mem_ready[d] = 1'b0;
            mem_rdata[d] = '0;
        end

        // Byte-addressed program, RESET_PC = 0x100
        ta.push_back(v_op(enc_i(5, 0, 3'd0, 1, OPIMM),              32'h100, 1'b0));
        ta.push_back(v_st(enc_s(8, 1, 0, 3'd2),                     32'h104, 32'h8, 2'd2, 32'h5, 2));
        ta.push_back(v_ld(enc_i(0, 0, 3'd0, 2, LOAD),               32'h108, 32'h0, 2'd0, 32'h12345680, 1));
        ta.push_back(v_ld(enc_i(0, 0, 3'd4, 3, LOAD),               32'h10C, 32'h0, 2'd0, 32'hABCDEF80, 0));
        ta.push_back(v_ld(enc_i(2, 0, 3'd1, 6, LOAD),               32'h110, 32'h2, 2'd1, 32'h77778001, 0));
        ta.push_back(v_st(enc_s(16, 2, 0, 3'd2),                    32'h114, 32'h10, 2'd2, 32'hFFFFFF80, 0));
        ta.push_back(v_st(enc_s(20, 3, 0, 3'd2),                    32'h118, 32'h14, 2'd2, 32'h00000080, 0));
        ta.push_back(v_st(enc_s(24, 6, 0, 3'd2),                    32'h11C, 32'h18, 2'd2, 32'hFFFF8001, 0));
        ta.push_back(v_op(enc_i(-1, 0, 3'd0, 4, OPIMM),             32'h120, 1'b0));
        ta.push_back(v_op(enc_i(1, 0, 3'd0, 5, OPIMM),              32'h124, 1'b0));
        ta.push_back(v_op(enc_b(16, 5, 4, 3'd4),                    32'h128, 1'b0));
        ta.push_back(v_op(enc_b(16, 5, 4, 3'd6),                    32'h138, 1'b0));
        ta.push_back(v_st(enc_s(3, 4, 5, 3'd0),                     32'h13C, 32'h4, 2'd0, 32'h000000FF, 1));
        ta.push_back(v_st(enc_s(0, 4, 0, 3'd1),                     32'h140, 32'h0, 2'd1, 32'h0000FFFF, 0));
        ta.push_back(v_op(enc_i(32'h200, 0, 3'd0, 1, OPIMM),        32'h144, 1'b0));
        ta.push_back(v_op(enc_j(-32'sh108, 7),                      32'h148, 1'b0));
        ta.push_back(v_op(enc_i(3, 1, 3'd0, 1, JALR),               32'h040, 1'b0));
        ta.push_back(v_st(enc_s(0, 1, 0, 3'd2),                     32'h202, 32'h0, 2'd2, 32'h00000044, 0));
        ta.push_back(v_st(enc_s(4, 7, 0, 3'd2),                     32'h206, 32'h4, 2'd2, 32'h0000014C, 0));
        ta.push_back(v_op(enc_i(7, 0, 3'd0, 0, OPIMM),              32'h20A, 1'b0));
        ta.push_back(v_st(enc_s(8, 0, 0, 3'd2),                     32'h20E, 32'h8, 2'd2, 32'h0, 0));
        ta.push_back(v_op(enc_u(20'hABCDE, 8, LUI),                 32'h212, 1'b0));
        ta.push_back(v_op(enc_u(20'h00001, 9, AUIPC),               32'h216, 1'b0));
        ta.push_back(v_st(enc_s(-4, 9, 5, 3'd2),                    32'h21A, 32'hFFFFFFFD, 2'd2, 32'h00001216, 0));
        ta.push_back(v_st(enc_s(0, 8, 0, 3'd2),                     32'h21E, 32'h0, 2'd2, 32'hABCDE000, 0));
        ta.push_back(v_op(32'h0000007F,                             32'h222, 1'b1));
        ta.push_back(v_op(enc_b(8, 0, 0, 3'd2),                     32'h226, 1'b1));
        ta.push_back(v_op(enc_i(0, 0, 3'd3, 10, LOAD),              32'h22A, 1'b1));
        ta.push_back(v_op(enc_b(8, 0, 5, 3'd1),                     32'h22E, 1'b0));
        ta.push_back(v_op(enc_b(8, 5, 4, 3'd5),                     32'h236, 1'b0));
        ta.push_back(v_op(enc_b(-8, 5, 4, 3'd7),                    32'h23A, 1'b0));
        ta.push_back(v_op(enc_b(32'h100, 5, 5, 3'd0),               32'h232, 1'b0));

        // Word-addressed program: PC step 1, branch/jump offsets divided by 4
        tb_w.push_back(v_op(enc_i(-1, 0, 3'd0, 4, OPIMM),           32'h100, 1'b0));
        tb_w.push_back(v_op(enc_i(1, 0, 3'd0, 5, OPIMM),            32'h101, 1'b0));
        tb_w.push_back(v_op(enc_b(16, 5, 4, 3'd4),                  32'h102, 1'b0));
        tb_w.push_back(v_op(enc_j(8, 6),                            32'h106, 1'b0));
        tb_w.push_back(v_st(enc_s(0, 6, 0, 3'd2),                   32'h108, 32'h0, 2'd2, 32'h00000107, 0));

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_req%0d", d), 32'(mem_req[d]), 32'd0);
            chk($sformatf("rst_we%0d", d),  32'(mem_we[d]),  32'd0);
            chk($sformatf("rst_prc%0d", d), prc[d], 32'h100);
            chk($sformatf("rst_ill%0d", d), 32'(illegal[d]), 32'd0);
        end
        rts_n = 1'b1;
        #1;

        foreach (ta[i]) run_vec(0, ta[i], i, (i % 3 == 1) ? 1 : 0);
        chk("a_tail_faddr", mem_addr[0], 32'h332);

        foreach (tb_w[i]) run_vec(1, tb_w[i], i, 0);
        chk("b_tail_faddr", mem_addr[1], 32'h109);
        chk("b_tail_freq", 32'(mem_req[1]), 32'd1);

        // Reset in the middle of a stalled store
        mem_rdata[0] = enc_s(0, 5, 0, 3'd2);
        mem_ready[0] = 1'b1;
        @(negedge clk);
        mem_ready[0] = 1'b0;
        @(negedge clk);
        repeat (2) begin
            chk("mid_mreq", 32'(mem_req[0]), 32'd1);
            chk("mid_mwe", 32'(mem_we[0]), 32'd1);
            chk("mid_wdata", mem_wdata[0], 32'd1);
            @(negedge clk);
        end
        #2 rts_n = 1'b0;
        #1;
        chk("rstmid_req", 32'(mem_req[0]), 32'd0);
        chk("rstmid_we", 32'(mem_we[0]), 32'd0);
        chk("rstmid_prc", prc[0], 32'h100);
        @(negedge clk);
        rts_n = 1'b1;
        #1;
        chk("rel_faddr", mem_addr[0], 32'h100);
        run_vec(0, v_op(enc_i(5, 0, 3'd0, 1, OPIMM), 32'h100, 1'b0), 99, 0);
        chk("rel_next_faddr", mem_addr[0], 32'h104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
